// File: rtl/mux2_arbiter.sv
// Two-source valid/ready arbiter with bounded bursts and a registered output stage.
// Grants alternate fairly when both sources stay busy; sel mirrors the active grant.
module mux2_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             i0_valid,
    input  logic [WIDTH-1:0] i0_data,
    output logic             i0_ready,

    input  logic             i1_valid,
    input  logic [WIDTH-1:0] i1_data,
    output logic             i1_ready,

    output logic             sel,

    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    input  logic             y_ready,

    output logic [1:0]       o_dbg_state,
    output logic             o_dbg_last_served
);

    // Handshake rule on every channel: a beat moves on a rising edge where
    // valid && ready are both high; valid must not depend on ready.

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(MAX_BURST - 1);

    state_t           r_state;
    logic             r_sel;
    logic [3:0]       r_cnt;
    logic             r_last;
    logic             r_y_valid;
    logic [WIDTH-1:0] r_y_data;

    logic w_load_ok;
    logic w_acc0;
    logic w_acc1;

    // The output register can take a new beat when empty or draining this cycle.
    assign w_load_ok = !r_y_valid || y_ready;
    assign i0_ready  = w_load_ok && (r_state == ST_GRANT0);
    assign i1_ready  = w_load_ok && (r_state == ST_GRANT1);
    assign w_acc0    = i0_valid && i0_ready;
    assign w_acc1    = i1_valid && i1_ready;

    assign sel               = r_sel;
    assign y_valid           = r_y_valid;
    assign y_data            = r_y_data;
    assign o_dbg_state       = r_state;
    assign o_dbg_last_served = r_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_sel     <= 1'b0;
            r_cnt     <= 4'd0;
            r_last    <= 1'b1;
            r_y_valid <= 1'b0;
            r_y_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // r_last names the source served most recently; the other wins a tie.
                    if (i0_valid && (!i1_valid || r_last)) begin
                        r_state <= ST_GRANT0;
                        r_sel   <= 1'b0;
                    end else if (i1_valid) begin
                        r_state <= ST_GRANT1;
                        r_sel   <= 1'b1;
                    end
                end

                ST_GRANT0: begin
                    if (!i0_valid) begin
                        r_cnt  <= 4'd0;
                        r_last <= 1'b0;
                        if (i1_valid) begin
                            r_state <= ST_GRANT1;
                            r_sel   <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_sel   <= 1'b0;
                        end
                    end else if (w_acc0) begin
                        if (r_cnt == CNT_LAST) begin
                            r_cnt <= 4'd0;
                            if (i1_valid) begin
                                r_state <= ST_GRANT1;
                                r_sel   <= 1'b1;
                                r_last  <= 1'b0;
                            end
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end

                ST_GRANT1: begin
                    if (!i1_valid) begin
                        r_cnt  <= 4'd0;
                        r_last <= 1'b1;
                        r_sel  <= 1'b0;
                        if (i0_valid) begin
                            r_state <= ST_GRANT0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else if (w_acc1) begin
                        if (r_cnt == CNT_LAST) begin
                            r_cnt <= 4'd0;
                            if (i0_valid) begin
                                r_state <= ST_GRANT0;
                                r_sel   <= 1'b0;
                                r_last  <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_sel   <= 1'b0;
                    r_cnt   <= 4'd0;
                end
            endcase

            // Accepting a beat wins over draining, so drain+accept keeps y_valid high.
            if (w_acc0) begin
                r_y_data  <= i0_data;
                r_y_valid <= 1'b1;
            end else if (w_acc1) begin
                r_y_data  <= i1_data;
                r_y_valid <= 1'b1;
            end else if (r_y_valid && y_ready) begin
                r_y_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed bench for mux2_arbiter: reset, single source, fairness,
// backpressure, early release and reset mid-burst.
module tb_mux2_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i0_valid = 1'b0;
    logic [7:0] i0_data = 8'h00;
    logic       i0_ready;
    logic       i1_valid = 1'b0;
    logic [7:0] i1_data = 8'h00;
    logic       i1_ready;
    logic       sel;
    logic       y_valid;
    logic [7:0] y_data;
    logic       y_ready = 1'b1;
    logic [1:0] dbg_state;
    logic       dbg_last;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    mux2_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .i0_valid          (i0_valid),
        .i0_data           (i0_data),
        .i0_ready          (i0_ready),
        .i1_valid          (i1_valid),
        .i1_data           (i1_data),
        .i1_ready          (i1_ready),
        .sel               (sel),
        .y_valid           (y_valid),
        .y_data            (y_data),
        .y_ready           (y_ready),
        .o_dbg_state       (dbg_state),
        .o_dbg_last_served (dbg_last)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) step();
    endtask

    initial begin
        logic hs0, hs1;
        logic [7:0] exp;

        // Reset held 2 cycles with both sources valid
        i0_valid = 1'b1; i0_data = 8'h55;
        i1_valid = 1'b1; i1_data = 8'h66;
        y_ready  = 1'b1;
        do_reset(2);
        check_eq("rst_y_valid", y_valid, 0);
        check_eq("rst_sel", sel, 0);
        check_eq("rst_i0_ready", i0_ready, 0);
        check_eq("rst_i1_ready", i1_ready, 0);
        check_eq("rst_y_data", y_data, 8'h00);
        check_eq("rst_state", dbg_state, 0);
        check_eq("rst_last", dbg_last, 1);

        // Single source: 6 beats cross the burst-counter wrap without a bubble
        reset = 1'b0; i1_valid = 1'b0; i0_valid = 1'b1; i0_data = 8'h10;
        step();
        check_eq("single_grant_state", dbg_state, 1);
        check_eq("single_grant_i0_ready", i0_ready, 1);
        check_eq("single_first_y_valid", y_valid, 0);
        for (int k = 0; k < 6; k++) begin
            step();
            check_eq("single_y_valid", y_valid, 1);
            check_eq("single_y_data", y_data, 8'h10 + k);
            check_eq("single_sel", sel, 0);
            i0_data = 8'h11 + k;
        end
        i0_valid = 1'b0;
        step();
        check_eq("single_drain_y_valid", y_valid, 0);
        check_eq("single_idle_state", dbg_state, 0);

        // Fairness: both sources always valid, bursts of 4 alternate
        i0_valid = 1'b1; i0_data = 8'hA0;
        i1_valid = 1'b1; i1_data = 8'hB0;
        do_reset(1);
        reset = 1'b0;
        for (int r = 0; r < 4; r++)
            for (int b = 0; b < 4; b++)
                exp_q.push_back(((r % 2) ? 8'hB0 : 8'hA0) + 8'((r / 2) * 4 + b));
        step();
        check_eq("fair_first_state", dbg_state, 1);
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            hs0 = i0_valid && i0_ready;
            hs1 = i1_valid && i1_ready;
            step();
            exp = exp_q.pop_front();
            check_eq("fair_y_valid", y_valid, 1);
            check_eq("fair_y_data", y_data, exp);
            check_eq("fair_sel", sel, ((j + 1) / 4) % 2);
            if (hs0) i0_data = i0_data + 8'd1;
            if (hs1) i1_data = i1_data + 8'd1;
        end
        check_eq("fair_q_empty", exp_q.size(), 0);

        // Backpressure: hold 0x42 for 5 cycles, then 0x43 follows exactly once
        i0_valid = 1'b1; i0_data = 8'h42; i1_valid = 1'b0;
        do_reset(1);
        reset = 1'b0;
        step();
        step();
        check_eq("bp_first_y_data", y_data, 8'h42);
        i0_data = 8'h43;
        y_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check_eq("bp_hold_y_valid", y_valid, 1);
            check_eq("bp_hold_y_data", y_data, 8'h42);
            check_eq("bp_i0_ready", i0_ready, 0);
            check_eq("bp_i1_ready", i1_ready, 0);
            check_eq("bp_state", dbg_state, 1);
        end
        y_ready = 1'b1;
        step();
        check_eq("bp_next_y_valid", y_valid, 1);
        check_eq("bp_next_y_data", y_data, 8'h43);
        i0_valid = 1'b0;
        step();
        check_eq("bp_end_y_valid", y_valid, 0);

        // Early release: i0 sends 2 beats and drops, i1 takes over immediately
        i0_valid = 1'b1; i0_data = 8'h20;
        i1_valid = 1'b1; i1_data = 8'h30;
        do_reset(1);
        reset = 1'b0;
        step();
        step();
        check_eq("early_beat0", y_data, 8'h20);
        i0_data = 8'h21;
        step();
        check_eq("early_beat1", y_data, 8'h21);
        i0_valid = 1'b0;
        step();
        check_eq("early_sel", sel, 1);
        check_eq("early_state", dbg_state, 2);
        check_eq("early_last", dbg_last, 0);
        check_eq("early_i1_ready", i1_ready, 1);
        check_eq("early_y_valid", y_valid, 0);
        step();
        check_eq("early_i1_beat0", y_data, 8'h30);
        i1_data = 8'h31;
        step();
        check_eq("early_i1_beat1", y_data, 8'h31);

        // Reset mid-burst after the 2nd beat of the GRANT1 burst
        i0_valid = 1'b1;
        reset = 1'b1;
        step();
        check_eq("midrst_y_valid", y_valid, 0);
        check_eq("midrst_state", dbg_state, 0);
        check_eq("midrst_sel", sel, 0);
        check_eq("midrst_i0_ready", i0_ready, 0);
        check_eq("midrst_i1_ready", i1_ready, 0);
        check_eq("midrst_last", dbg_last, 1);
        reset = 1'b0;
        step();
        check_eq("midrst_grant_state", dbg_state, 1);
        check_eq("midrst_grant_sel", sel, 0);
        check_eq("midrst_i0_ready_after", i0_ready, 1);
        step();
        check_eq("midrst_beat_y_valid", y_valid, 1);
        check_eq("midrst_beat_y_data", y_data, 8'h21);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
